// File: rtl/cpu_boot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_boot_sequencer - loads imem/dmem images, runs the cpu for a cycle
// budget, then streams a window of dmem back out.  Rev 1.0
// ---------------------------------------------------------------------------
module cpu_boot_sequencer #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [9:0]       imem_len,
  input  logic [10:0]      dmem_len,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [10:0]      dump_len,
  input  logic             s_valid,
  input  logic [63:0]      s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [63:0]      m_data,
  input  logic             m_ready,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_GAP, S_RUN, S_DUMP, S_DONE
  } state_t;

  // Dump sub-phase: read strobe out, read data returning, word presented.
  typedef enum logic [1:0] {D_READ, D_CAPT, D_HOLD} dphase_t;

  state_t           state, state_nx;
  state_t           after_run, after_gap, after_start;
  dphase_t          dphase;
  logic [10:0]      ilen, dlen, dnum, idx;
  logic [10:0]      ilen_cl, dlen_cl, dnum_cl;
  logic [CNT_W-1:0] run_len, run_cnt;
  logic             start_ok, load_hs, load_last, run_last;
  logic             dump_acc, dump_last, enter_dump;

  always_comb begin
    ilen_cl = ({1'b0, imem_len} > 11'(IMEM_WORDS)) ? 11'(IMEM_WORDS) : {1'b0, imem_len};
    dlen_cl = (dmem_len > 11'(DMEM_WORDS)) ? 11'(DMEM_WORDS) : dmem_len;
    dnum_cl = (dump_len > 11'(DMEM_WORDS)) ? 11'(DMEM_WORDS) : dump_len;
  end

  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign s_ready    = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign load_hs    = s_valid && s_ready;
  assign load_last  = (state == S_LOAD_I) ? (idx == ilen - 11'd1) : (idx == dlen - 11'd1);
  assign run_last   = (run_cnt == run_len - CNT_W'(1));
  assign dump_acc   = (state == S_DUMP) && (dphase == D_HOLD) && m_ready;
  assign dump_last  = (idx == dnum - 11'd1);
  assign enter_dump = (state_nx == S_DUMP) && (state != S_DUMP);

  assign cpu_enable = (state == S_RUN);
  assign busy       = !((state == S_IDLE) || (state == S_DONE));
  assign done       = (state == S_DONE);
  assign ren_ext    = 1'b0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Zero-length phases fall straight through to the next one in order.
  always_comb begin
    after_run   = (dnum != 11'd0) ? S_DUMP : S_DONE;
    after_gap   = (run_len != '0) ? S_RUN : after_run;
    after_start = (ilen_cl != 11'd0) ? S_LOAD_I :
                  (dlen_cl != 11'd0) ? S_LOAD_D : S_GAP;
    state_nx    = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nx = after_start;
      S_LOAD_I: if (load_hs && load_last) state_nx = (dlen != 11'd0) ? S_LOAD_D : S_GAP;
      S_LOAD_D: if (load_hs && load_last) state_nx = S_GAP;
      S_GAP:    state_nx = after_gap;
      S_RUN:    if (run_last) state_nx = after_run;
      S_DUMP:   if (dump_acc && dump_last) state_nx = S_DONE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ilen        <= '0;
      dlen        <= '0;
      dnum        <= '0;
      run_len     <= '0;
      idx         <= '0;
      run_cnt     <= '0;
      dphase      <= D_READ;
      m_valid     <= 1'b0;
      m_data      <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      ren_ext_2 <= 1'b0;
      if (start_ok) begin
        ilen    <= ilen_cl;
        dlen    <= dlen_cl;
        dnum    <= dnum_cl;
        run_len <= run_cycles;
        idx     <= '0;
        run_cnt <= '0;
        m_valid <= 1'b0;
      end
      if (load_hs) begin
        idx <= load_last ? 11'd0 : idx + 11'd1;
        if (state == S_LOAD_I) begin
          wen_ext   <= 1'b1;
          addr_ext  <= {51'd0, idx, 2'b00};
          wdata_ext <= s_data[31:0];
        end else begin
          wen_ext_2   <= 1'b1;
          addr_ext_2  <= {50'd0, idx, 3'b000};
          wdata_ext_2 <= s_data;
        end
      end
      if (state == S_RUN) run_cnt <= run_cnt + CNT_W'(1);
      // The first read is launched on the way in so ren lands in the first DUMP cycle.
      if (enter_dump) begin
        idx        <= '0;
        ren_ext_2  <= 1'b1;
        addr_ext_2 <= '0;
        dphase     <= D_READ;
      end
      if (state == S_DUMP) begin
        case (dphase)
          D_READ: dphase <= D_CAPT;
          D_CAPT: begin
            m_data  <= rdata_ext_2;
            m_valid <= 1'b1;
            dphase  <= D_HOLD;
          end
          default: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              if (!dump_last) begin
                idx        <= idx + 11'd1;
                ren_ext_2  <= 1'b1;
                addr_ext_2 <= {50'd0, idx + 11'd1, 3'b000};
                dphase     <= D_READ;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_boot_sequencer - stimulus pushes expected writes, run lengths and dump
// words into queues; a negedge monitor drains and checks them.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cpu_boot_sequencer;
  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;
  localparam int CNT_W      = 32;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic [9:0]       imem_len = '0;
  logic [10:0]      dmem_len = '0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic [10:0]      dump_len = '0;
  logic             s_valid = 1'b0;
  logic [63:0]      s_data = '0;
  logic             s_ready;
  logic             m_valid;
  logic [63:0]      m_data;
  logic             m_ready = 1'b0;
  logic             cpu_enable;
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2 = '0;
  logic             busy;
  logic             done;

  cpu_boot_sequencer #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_len(imem_len), .dmem_len(dmem_len),
    .run_cycles(run_cycles), .dump_len(dump_len), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [95:0]  imem_q[$];
  logic [127:0] dmem_q[$];
  logic [63:0]  dump_q[$];
  int           run_q[$];
  int           reads_q[$];
  logic [63:0]  ref_mem [DMEM_WORDS];
  logic [63:0]  env_mem [DMEM_WORDS];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input int k);
    return {32'(k) * 32'h9E3779B9, ~32'(k)};
  endfunction

  // Data memory: one-cycle read latency, garbage on the bus when not reading.
  initial begin
    for (int k = 0; k < DMEM_WORDS; k++) env_mem[k] = init_word(k);
    forever begin
      @(posedge clk);
      if (wen_ext_2) env_mem[addr_ext_2[12:3]] <= wdata_ext_2;
      rdata_ext_2 <= ren_ext_2 ? env_mem[addr_ext_2[12:3]] : {$urandom, $urandom};
    end
  end

  int          cyc = 0, ref_en = 0, ref_done = 0, en_run = 0, n_reads = 0;
  logic        prev_en = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
  logic [63:0] prev_mdata = '0;

  always @(negedge clk) begin
    cyc++;
    if (!arst_n) begin
      prev_en = 1'b0; en_run = 0; prev_stall = 1'b0; prev_done = 1'b0;
    end else begin
      if (start && !busy) begin ref_en = cyc; ref_done = cyc + 2; n_reads = 0; end
      if (s_valid && s_ready) begin ref_en = cyc; ref_done = cyc + 2; end
      if (wen_ext || wen_ext_2 || ren_ext_2 || cpu_enable)
        chk("strobe_exclusive", int'(wen_ext) + int'(wen_ext_2) + int'(ren_ext_2) + int'(cpu_enable), 1);
      if (wen_ext) begin
        if (imem_q.size() == 0) chk("imem_write_pending", imem_q.size(), 1);
        else chk("imem_write", {addr_ext, wdata_ext}, imem_q.pop_front());
      end
      if (wen_ext_2) begin
        if (dmem_q.size() == 0) chk("dmem_write_pending", dmem_q.size(), 1);
        else chk("dmem_write", {addr_ext_2, wdata_ext_2}, dmem_q.pop_front());
      end
      if (ren_ext_2) n_reads++;
      if (prev_stall) chk("m_data_hold", {m_valid, m_data}, {1'b1, prev_mdata});
      if (m_valid && m_ready) begin
        ref_done = cyc + 1;
        if (dump_q.size() == 0) chk("dump_word_pending", dump_q.size(), 1);
        else chk("dump_word", m_data, dump_q.pop_front());
      end
      if (cpu_enable) begin
        if (!prev_en) chk("enable_rise_delay", cyc - ref_en, 2);
        en_run++;
        ref_done = cyc + 1;
      end else if (prev_en) begin
        if (run_q.size() == 0) chk("run_pending", run_q.size(), 1);
        else chk("enable_cycles", en_run, run_q.pop_front());
        en_run = 0;
      end
      if (done && !prev_done) begin
        chk("done_cycle", cyc, ref_done);
        chk("dump_reads", n_reads, (reads_q.size() != 0) ? reads_q.pop_front() : -1);
        chk("queues_drained", imem_q.size() + dmem_q.size() + dump_q.size() + run_q.size(), 0);
        chk("ren_ext_idle", ren_ext, 1'b0);
      end
      prev_en    = cpu_enable;
      prev_done  = done;
      prev_stall = m_valid && !m_ready;
      prev_mdata = m_data;
    end
  end

  // vmode: 0 valid held, 1 toggling, 2 random.  rmode: 0 ready held, 1 random,
  // 2 four-cycle stall on dump word 1.  abort_en > 0 resets after that many
  // enable cycles.  poke_at pulses start while presenting that load word.
  task automatic run_seq(input int il, input int dl, input int rc, input int dn,
                         input int vmode, input int rmode, input int abort_en, input int poke_at);
    int ic, dc, nc, accepted, stall, en_seen;
    logic hs;
    logic [63:0] w;
    ic = (il > IMEM_WORDS) ? IMEM_WORDS : il;
    dc = (dl > DMEM_WORDS) ? DMEM_WORDS : dl;
    nc = (dn > DMEM_WORDS) ? DMEM_WORDS : dn;
    @(posedge clk); #1;
    imem_len = 10'(il); dmem_len = 11'(dl); run_cycles = CNT_W'(rc); dump_len = 11'(dn);
    if (rc > 0) run_q.push_back(rc);
    reads_q.push_back(nc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    imem_len = 10'($urandom); dmem_len = 11'($urandom); dump_len = 11'($urandom);
    run_cycles = CNT_W'($urandom);
    for (int n = 0; n < ic + dc; n++) begin
      w = {$urandom, $urandom};
      if (n < ic) imem_q.push_back({64'(4 * n), w[31:0]});
      else begin
        dmem_q.push_back({64'(8 * (n - ic)), w});
        ref_mem[n - ic] = w;
      end
      s_data = w;
      hs = 1'b0;
      for (int g = 0; g < 40 && !hs; g++) begin
        case (vmode)
          0:       s_valid = 1'b1;
          1:       s_valid = ~s_valid;
          default: s_valid = 1'($urandom_range(0, 1));
        endcase
        start = (n == poke_at) && (g == 0);
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!hs) chk("load_handshake", hs, 1'b1);
    end
    s_valid = 1'b0;
    for (int k = 0; k < nc; k++) dump_q.push_back(ref_mem[k]);
    accepted = 0; stall = 0; en_seen = 0;
    for (int g = 0; g < rc + 8 * nc + 40 && !done; g++) begin
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (m_valid && accepted == 1 && stall < 4) begin m_ready = 1'b0; stall++; end
          else m_ready = 1'b1;
        end
      endcase
      @(negedge clk);
      if (m_valid && m_ready) accepted++;
      if (cpu_enable) en_seen++;
      @(posedge clk); #1;
      if (abort_en > 0 && en_seen >= abort_en) begin
        chk("enable_before_reset", cpu_enable, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {cpu_enable, busy, done, s_ready, m_valid, wen_ext, wen_ext_2, ren_ext_2}, 8'd0);
        chk("async_reset_data", {addr_ext, addr_ext_2}, 128'd0);
        imem_q.delete(); dmem_q.delete(); dump_q.delete(); run_q.delete(); reads_q.delete();
        m_ready = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        return;
      end
    end
    m_ready = 1'b0;
    if (!done) chk("sequence_done", done, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < DMEM_WORDS; k++) ref_mem[k] = init_word(k);
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {busy, done, cpu_enable, s_ready, m_valid, wen_ext, wen_ext_2, ren_ext_2, ren_ext}, 9'd0);
    chk("reset_data", {addr_ext, addr_ext_2}, 128'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, done}, 2'b00);

    run_seq(3, 0, 0, 0, 0, 0, 0, -1);
    run_seq(0, 2, 0, 0, 1, 0, 0, -1);
    run_seq(1, 1, 5, 0, 0, 0, 0, -1);
    run_seq(0, 0, 0, 3, 0, 2, 0, -1);
    run_seq(2, 2, 40, 2, 0, 0, 5, -1);
    chk("idle_after_abort", {busy, done, cpu_enable}, 3'b000);
    run_seq(2, 2, 3, 2, 0, 1, 0, -1);
    run_seq(2, 4, 0, 1, 0, 0, 0, 3);
    run_seq(600, 0, 0, 0, 0, 0, 0, -1);
    run_seq(0, 0, 0, 1100, 0, 0, 0, -1);
    for (int r = 0; r < 8; r++)
      run_seq($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 8),
              $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 1), 0, -1);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
